// File: rtl/serial_deser_32.sv
// Framed serial-to-parallel receiver with a double-buffered valid/ready output word.
// Latency: the word is valid 1 clk after its last strobe; a completed word is dropped (overrun) only when the output slot is still held.
module serial_deser_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             s_valid,
    input  logic             s_first,
    input  logic             s_data,
    input  logic             dir,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] q_data_q, q_data_d;
    logic             q_valid_q, q_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             word_done;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        q_data_d    = q_data_q;
        q_valid_d   = q_valid_q & ~q_ready;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        word_done   = 1'b0;

        if (s_valid) begin
            if (s_first) begin
                // A first bit always starts a fresh word; any partial word is abandoned.
                frame_err_d = (state_q == SHIFT);
                dir_d       = dir;
                sr_d        = dir ? {s_data, {(WIDTH-1){1'b0}}}
                                  : {{(WIDTH-1){1'b0}}, s_data};
                cnt_d       = CNT_W'(1);
                state_d     = SHIFT;
            end else if (state_q == SHIFT) begin
                sr_d  = dir_q ? {s_data, sr_q[WIDTH-1:1]}
                              : {sr_q[WIDTH-2:0], s_data};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == FULL) begin
                    word_done = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end
        end

        // Slot counts as free if the consumer takes the held word at this same edge.
        if (word_done) begin
            if (!q_valid_q || q_ready) begin
                q_data_d  = sr_d;
                q_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            q_data_q    <= '0;
            q_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            q_data_q    <= q_data_d;
            q_valid_q   <= q_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign q_data    = q_data_q;
    assign q_valid   = q_valid_q;
    assign busy      = (state_q == SHIFT);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
